chain_pipe: RTL and testbench
=============================

// Module: chain_pipe
// PURPOSE
//  Parametrised successor to the fixed 8-bit stage chain. Data passes through NSTAGES processing stages.
//  Each stage applies an op chosen at elaboration. Any stage output, and the final output, can be registered.
//  A valid/ready handshake with backpressure runs end to end, and an occupancy count is reported.
//  Sits between a streaming source and sink in the system top.
// PARAMETERS
//  WIDTH       8      data width in bits (>=2)
//  NSTAGES     4      number of chained stages (>=1)
//  OPS         0      [2*NSTAGES-1:0]; stage i op = OPS[2i+1:2i]: 0 pass, 1 invert, 2 +1 mod 2^WIDTH, 3 rotate-left-1
//  REG_MASK    '1     [NSTAGES-1:0]; bit i=1 -> register slot after stage i
//  OUTPUT_REG  1      1 -> extra register slot after last stage (after stage NSTAGES-1)
// PORTS
//  clk        in   1                        system clock, rising edge
//  rst        in   1                        synchronous, active-high reset
//  in_data    in   WIDTH                    input word
//  in_valid   in   1                        input word valid
//  in_ready   out  1                        block accepts input this cycle
//  out_data   out  WIDTH                    result word
//  out_valid  out  1                        result valid
//  out_ready  in   1                        sink accepts result this cycle
//  occupancy  out  $clog2(NSTAGES+2)        number of valid register slots
// BEHAVIOUR
//  - One clock (clk); reset rst is synchronous and active-high, sampled on rising clk.
//  - Slot count S = popcount(REG_MASK) + OUTPUT_REG. Each slot holds {valid, data}.
//  - Latency with no stall = S cycles from in_valid&in_ready to out_valid.
//  - Stage ops are combinational and operate on the value entering that stage.
//  - Slot k accepts when !valid_k || ready_{k+1}. ready_S = out_ready. in_ready = ready_0.
//  - A slot captures when upstream valid && its own ready. A slot clears valid when its word is taken and
//    no new word arrives.
//  - A word transfers on a boundary only when valid && ready at that boundary. No word is dropped or duplicated.
//  - When out_valid=1 && out_ready=0, out_data and out_valid hold stable until accepted.
//  - Full throughput: with out_ready=1 the chain accepts one word per cycle. The ready path is combinational
//    end to end.
//  - Full: all S slots valid and out_ready=0 -> in_ready=0. A slot frees the same cycle out_ready rises.
//  - S=0: fully combinational. out_valid=in_valid, in_ready=out_ready, out_data=f(in_data), occupancy=0.
//  - Arithmetic: op 2 wraps (all-ones +1 -> 0). Op 3 is {d[WIDTH-2:0], d[WIDTH-1]}.
//  - occupancy = number of slots with valid=1, updated on the same edge as the slots.
//  - Reset: all slot valids=0 and data=0. Therefore out_valid=0, out_data=0 (S>0), occupancy=0.
//    in_ready=1 once out of reset (combinationally 1 during reset too).
//  - Reset mid-operation discards all in-flight words. No word from before reset may appear after it.
//  - A simultaneous in_valid and rst in the same cycle is not captured.
// TESTING
//  WIDTH=8, NSTAGES=3, OPS=6'b11_10_01, REG_MASK=3'b101, OUTPUT_REG=1 (S=3) unless stated otherwise.
//  1. Single word 0x0F, out_ready=1 -> out_data=0xE3 exactly 3 cycles later; occupancy 1,1,1 then 0.
//  2. Stream 0x00..0x0F back to back, out_ready=1 -> 16 outputs in order, one per cycle, in_ready stays 1.
//  3. Hold out_ready=0 and feed words -> exactly 3 accepted; in_ready=0; occupancy=3.
//     Raise out_ready -> all 3 drain in order with no loss.
//  4. Run with OPS=6'b10_10_10, input 0xFE -> out_data=0x01 (wrap). With NSTAGES=1, OPS=2'b11, input 0x80 -> 0x01.
//  5. Assert rst for 1 cycle with 3 words in flight -> out_valid=0, occupancy=0 next cycle.
//     None of the 3 words ever appears at the output.
//  6. Run with REG_MASK=0, OUTPUT_REG=0 -> out_valid follows in_valid in the same cycle;
//     in_ready equals out_ready; 0x0F -> 0xE3.

Source files
------------

// File: rtl/chain_if.sv
// chain_if: valid/ready stream carrying one WIDTH-bit word per transfer
interface chain_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] data;
  logic valid;
  logic ready;
  modport master(output data, valid, input ready);
  modport slave(input data, valid, output ready);
endinterface

// File: rtl/chain_pipe.sv
// chain_pipe: NSTAGES elaboration-chosen ops with optional register slots and end-to-end valid/ready
module chain_pipe #(
  parameter int WIDTH = 8,
  parameter int NSTAGES = 4,
  parameter logic [2*NSTAGES-1:0] OPS = '0,
  parameter logic [NSTAGES-1:0] REG_MASK = '1,
  parameter bit OUTPUT_REG = 1'b1,
  localparam int OW = $clog2(NSTAGES + 2)
) (
  input logic clk,
  input logic rst,
  chain_if.slave in_s,
  chain_if.master out_m,
  output logic [OW-1:0] occupancy
);
  localparam int S = $countones(REG_MASK) + int'(OUTPUT_REG);
  logic [WIDTH-1:0] d [NSTAGES+1];
  logic v [NSTAGES+1];
  logic r [NSTAGES+1];
  logic [NSTAGES:0] vs;
  function automatic logic [WIDTH-1:0] op(input logic [1:0] o, input logic [WIDTH-1:0] x);
    return o == 2'd0 ? x : o == 2'd1 ? ~x : o == 2'd2 ? x + WIDTH'(1) : {x[WIDTH-2:0], x[WIDTH-1]};
  endfunction
  assign d[0] = in_s.data;
  assign v[0] = in_s.valid;
  assign in_s.ready = r[0] || (S > 0 && rst);
  for (genvar i = 0; i < NSTAGES; i++) begin : g_st
    logic [WIDTH-1:0] f;
    assign f = op(OPS[2*i +: 2], d[i]);
    if (REG_MASK[i]) begin : g_reg
      logic sv;
      logic [WIDTH-1:0] sd;
      always_ff @(posedge clk)
        if (rst) begin
          sv <= 1'b0;
          sd <= '0;
        end else if (r[i]) begin
          sv <= v[i];
          if (v[i]) sd <= f;
        end
      assign r[i] = !sv || r[i+1];
      assign v[i+1] = sv;
      assign d[i+1] = sd;
      assign vs[i] = sv;
    end else begin : g_comb
      assign r[i] = r[i+1];
      assign v[i+1] = v[i];
      assign d[i+1] = f;
      assign vs[i] = 1'b0;
    end
  end
  if (OUTPUT_REG) begin : g_out
    logic ov;
    logic [WIDTH-1:0] od;
    always_ff @(posedge clk)
      if (rst) begin
        ov <= 1'b0;
        od <= '0;
      end else if (r[NSTAGES]) begin
        ov <= v[NSTAGES];
        if (v[NSTAGES]) od <= d[NSTAGES];
      end
    assign r[NSTAGES] = !ov || out_m.ready;
    assign out_m.valid = ov;
    assign out_m.data = od;
    assign vs[NSTAGES] = ov;
  end else begin : g_noout
    assign r[NSTAGES] = out_m.ready;
    assign out_m.valid = v[NSTAGES];
    assign out_m.data = d[NSTAGES];
    assign vs[NSTAGES] = 1'b0;
  end
  always_comb begin
    occupancy = '0;
    for (int k = 0; k <= NSTAGES; k++) occupancy = occupancy + OW'(vs[k]);
  end
endmodule

// File: tb/tb_chain_pipe.sv
// tb_chain_pipe: scoreboard bench for chain_pipe across several parameter sets
module tb_chain_pipe;
  logic clk, rst;
  logic [2:0] occ_a, occ_b, occ_d;
  logic [1:0] occ_c;
  int tests, fails, pops, accepted, p0, a0;
  int q[$];
  bit pend;
  logic [7:0] hold;
  chain_if #(8) ia(), oa(), ib(), ob(), ic(), oc(), id(), od();
  chain_pipe #(.WIDTH(8), .NSTAGES(3), .OPS(6'b11_10_01), .REG_MASK(3'b101), .OUTPUT_REG(1'b1))
    ua (.clk(clk), .rst(rst), .in_s(ia), .out_m(oa), .occupancy(occ_a));
  chain_pipe #(.WIDTH(8), .NSTAGES(3), .OPS(6'b10_10_10), .REG_MASK(3'b101), .OUTPUT_REG(1'b1))
    ub (.clk(clk), .rst(rst), .in_s(ib), .out_m(ob), .occupancy(occ_b));
  chain_pipe #(.WIDTH(8), .NSTAGES(1), .OPS(2'b11), .REG_MASK(1'b1), .OUTPUT_REG(1'b1))
    uc (.clk(clk), .rst(rst), .in_s(ic), .out_m(oc), .occupancy(occ_c));
  chain_pipe #(.WIDTH(8), .NSTAGES(3), .OPS(6'b11_10_01), .REG_MASK(3'b000), .OUTPUT_REG(1'b0))
    ud (.clk(clk), .rst(rst), .in_s(id), .out_m(od), .occupancy(occ_d));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  function automatic int model(int x, int ops, int n);
    for (int i = 0; i < n; i++)
      case ((ops >> (2 * i)) & 3)
        1: x = 255 - x;
        2: x = (x + 1) % 256;
        3: x = ((x * 2) % 256) + x / 128;
        default: ;
      endcase
    return x;
  endfunction
  task automatic chk(string n, int a, int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk)
    if (!rst && ia.valid && ia.ready) begin
      q.push_back(model(int'(ia.data), 6'b11_10_01, 3));
      accepted++;
    end
  always @(negedge clk)
    if (rst) begin
      q.delete();
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("stall_valid", oa.valid, 1);
        chk("stall_data", oa.data, hold);
      end
      if (oa.valid && oa.ready) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_out: got %0h with nothing expected", oa.data);
        end else begin
          chk("out_data", oa.data, q.pop_front());
          pops++;
        end
      end
      pend = oa.valid && !oa.ready;
      hold = oa.data;
    end
  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    ia.valid = 1'b0; ia.data = '0; oa.ready = 1'b1;
    ib.valid = 1'b1; ib.data = 8'hFE; ob.ready = 1'b1;
    ic.valid = 1'b1; ic.data = 8'h80; oc.ready = 1'b1;
    id.valid = 1'b0; id.data = '0; od.ready = 1'b0;
    step();
    step();
    chk("rst_in_ready", ia.ready, 1);
    chk("rst_out_valid", oa.valid, 0);
    chk("rst_out_data", oa.data, 0);
    chk("rst_occ", occ_a, 0);
    rst = 1'b0;
    // single word latency and occupancy profile
    ia.data = 8'h0F; ia.valid = 1'b1;
    step();
    ia.valid = 1'b0;
    chk("t1_occ1", occ_a, 1); chk("t1_v1", oa.valid, 0);
    step();
    chk("t1_occ2", occ_a, 1); chk("t1_v2", oa.valid, 0);
    step();
    chk("t1_occ3", occ_a, 1); chk("t1_v3", oa.valid, 1); chk("t1_data", oa.data, 8'hE3);
    step();
    chk("t1_occ4", occ_a, 0); chk("t1_v4", oa.valid, 0);
    p0 = pops;
    for (int k = 0; k < 16; k++) begin
      ia.data = 8'(k); ia.valid = 1'b1;
      chk("t2_in_ready", ia.ready, 1);
      step();
    end
    ia.valid = 1'b0;
    repeat (5) step();
    chk("t2_count", pops - p0, 16);
    oa.ready = 1'b0;
    a0 = accepted;
    repeat (6) begin
      ia.data = 8'($urandom); ia.valid = 1'b1;
      step();
    end
    ia.valid = 1'b0;
    chk("t3_accepted", accepted - a0, 3);
    chk("t3_in_ready", ia.ready, 0);
    chk("t3_occ", occ_a, 3);
    p0 = pops;
    oa.ready = 1'b1;
    #1;
    chk("t3_free_same_cycle", ia.ready, 1);
    repeat (4) step();
    chk("t3_drain", pops - p0, 3);
    chk("t3_sb_empty", q.size(), 0);
    // reset with a full chain and a word offered in the reset cycle
    oa.ready = 1'b0;
    repeat (3) begin
      ia.data = 8'($urandom); ia.valid = 1'b1;
      step();
    end
    chk("t5_full", occ_a, 3);
    ia.data = 8'($urandom); rst = 1'b1;
    step();
    rst = 1'b0; ia.valid = 1'b0;
    chk("t5_out_valid", oa.valid, 0);
    chk("t5_occ", occ_a, 0);
    p0 = pops;
    oa.ready = 1'b1;
    repeat (6) step();
    chk("t5_no_leak", pops - p0, 0);
    chk("t5_occ_after", occ_a, 0);
    for (int c = 0; c < 400; c++) begin
      ia.data = 8'($urandom); ia.valid = 1'($urandom_range(0, 1));
      oa.ready = $urandom_range(0, 3) != 0;
      step();
    end
    ia.valid = 1'b0; oa.ready = 1'b1;
    for (int c = 0; c < 20 && q.size() != 0; c++) step();
    step();
    chk("rand_drain", q.size(), 0);
    chk("rand_occ", occ_a, 0);
    chk("t4_wrap_valid", ob.valid, 1);
    chk("t4_wrap_data", ob.data, model(8'hFE, 6'b10_10_10, 3));
    chk("t4_rot_valid", oc.valid, 1);
    chk("t4_rot_data", oc.data, model(8'h80, 2'b11, 1));
    id.data = 8'h0F; id.valid = 1'b1; od.ready = 1'b1;
    #1;
    chk("t6_fixed_data", od.data, 8'hE3);
    for (int c = 0; c < 8; c++) begin
      id.data = 8'($urandom); id.valid = 1'($urandom_range(0, 1)); od.ready = 1'($urandom_range(0, 1));
      #1;
      chk("t6_valid", od.valid, id.valid);
      chk("t6_ready", id.ready, od.ready);
      chk("t6_data", od.data, model(int'(id.data), 6'b11_10_01, 3));
      chk("t6_occ", occ_d, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
